// File: rtl/grid_click_decoder_if.sv
// Bundles the cursor, button and click-handshake signals of the grid click decoder.
// The master side drives the cursor, button and consumer ready; the slave side is the decoder.
interface grid_click_decoder_if;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        click_ready;
  logic        hover_valid;
  logic [3:0]  hover_col;
  logic [3:0]  hover_row;
  logic        click_valid;
  logic [3:0]  click_col;
  logic [3:0]  click_row;

  modport master (
    output xpos, ypos, left, click_ready,
    input  hover_valid, hover_col, hover_row, click_valid, click_col, click_row
  );

  modport slave (
    input  xpos, ypos, left, click_ready,
    output hover_valid, hover_col, hover_row, click_valid, click_col, click_row
  );
endinterface

// File: rtl/grid_click_decoder.sv
// Maps a mouse cursor onto a 12x12 cell grid (32 px pitch, 2 px lines) and turns
// left-button presses inside a cell into single valid/ready click transactions.
//
// state    | meaning
// IDLE     | waiting for a synchronized button press
// PEND     | click latched; click_valid raised one cycle after entry, held until click_ready
// WAIT_REL | click consumed or press missed the grid; wait for button release
module grid_click_decoder #(
  parameter int X_POS = 0,
  parameter int Y_POS = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  grid_click_decoder_if.slave         bus
);

  localparam logic [11:0] XP       = 12'(X_POS);
  localparam logic [11:0] YP       = 12'(Y_POS);
  localparam logic [11:0] GRID_EXT = 12'd384;
  localparam logic [4:0]  LINE_W   = 5'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic        s1_q, s2_q, s3_q;
  logic        press;

  logic [11:0] dx, dy;
  logic        in_x, in_y, on_line, hit;
  logic [3:0]  col_c, row_c;

  logic        hover_valid_q;
  logic [3:0]  hover_col_q, hover_row_q;

  logic        click_valid_q, click_valid_d;
  logic [3:0]  click_col_q, click_col_d;
  logic [3:0]  click_row_q, click_row_d;

  // Offsets wrap when the cursor is left of / above the grid, so the lower bound is checked explicitly.
  always_comb begin
    dx      = bus.xpos - XP;
    dy      = bus.ypos - YP;
    in_x    = (bus.xpos >= XP) && (dx < GRID_EXT);
    in_y    = (bus.ypos >= YP) && (dy < GRID_EXT);
    on_line = (dx[4:0] < LINE_W) || (dy[4:0] < LINE_W);
    hit     = in_x && in_y && !on_line;
    col_c   = dx[8:5];
    row_c   = dy[8:5];
  end

  assign press = s2_q && !s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.left;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hover_valid_q <= 1'b0;
      hover_col_q   <= 4'd0;
      hover_row_q   <= 4'd0;
    end else begin
      hover_valid_q <= hit;
      hover_col_q   <= hit ? col_c : 4'd0;
      hover_row_q   <= hit ? row_c : 4'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    click_col_d = click_col_q;
    click_row_d = click_row_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (hit) begin
            state_d     = PEND;
            click_col_d = col_c;
            click_row_d = row_c;
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      PEND: begin
        // Only a handshake seen while click_valid is visible consumes the click.
        if (click_valid_q && bus.click_ready) begin
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!s2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    click_valid_d = (state_q == PEND) && (state_d == PEND);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      click_valid_q <= 1'b0;
      click_col_q   <= 4'd0;
      click_row_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      click_valid_q <= click_valid_d;
      click_col_q   <= click_col_d;
      click_row_q   <= click_row_d;
    end
  end

  assign bus.hover_valid = hover_valid_q;
  assign bus.hover_col   = hover_col_q;
  assign bus.hover_row   = hover_row_q;
  assign bus.click_valid = click_valid_q;
  assign bus.click_col   = click_col_q;
  assign bus.click_row   = click_row_q;

endmodule

// File: tb/tb_grid_click_decoder.sv
// Self-checking bench for grid_click_decoder with the grid placed at (100,50).
module tb_grid_click_decoder;

  localparam int XO = 100;
  localparam int YO = 50;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  grid_click_decoder_if bus ();

  grid_click_decoder #(.X_POS(XO), .Y_POS(YO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int   valid;
    int   col;
    int   row;
  } exp_t;

  typedef struct {
    int   x;
    int   y;
    int   valid;
    int   col;
    int   row;
  } hover_vec_t;

  exp_t        sb[$];
  hover_vec_t  vecs[14];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          accepted = 0;

  always @(negedge clk) begin
    if (rst_n && bus.click_valid && bus.click_ready) accepted++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int v, input int c, input int r);
    exp_t e;
    e.valid = v; e.col = c; e.row = r;
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_underflow: got 0 entries expected at least 1");
      e.valid = -1; e.col = -1; e.row = -1;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.click_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_click(input string name);
    exp_t e;
    pop_exp(e);
    chk({name, "_col"}, bus.click_col, e.col);
    chk({name, "_row"}, bus.click_row, e.row);
  endtask

  initial begin
    exp_t e;
    bit   ok;
    int   seen;
    int   acc0;

    vecs[0]  = '{170,  90, 1,  2,  1};
    vecs[1]  = '{164,  90, 0,  0,  0};
    vecs[2]  = '{ 99,  90, 0,  0,  0};
    vecs[3]  = '{484,  90, 0,  0,  0};
    vecs[4]  = '{170, 433, 1,  2, 11};
    vecs[5]  = '{485,  90, 0,  0,  0};
    vecs[6]  = '{486,  90, 0,  0,  0};
    vecs[7]  = '{101,  90, 0,  0,  0};
    vecs[8]  = '{102,  90, 1,  0,  1};
    vecs[9]  = '{170,  49, 0,  0,  0};
    vecs[10] = '{170,  51, 0,  0,  0};
    vecs[11] = '{483, 432, 1, 11, 11};
    vecs[12] = '{133,  90, 0,  0,  0};
    vecs[13] = '{134,  90, 1,  1,  1};

    rst_n           = 1'b0;
    bus.xpos        = 12'd170;
    bus.ypos        = 12'd90;
    bus.left        = 1'b0;
    bus.click_ready = 1'b0;
    #3;
    chk("rst_hover_valid", bus.hover_valid, 0);
    chk("rst_hover_col",   bus.hover_col,   0);
    chk("rst_click_valid", bus.click_valid, 0);
    chk("rst_click_col",   bus.click_col,   0);
    chk("rst_click_row",   bus.click_row,   0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Hover decode table: one cycle of latency per vector.
    foreach (vecs[i]) begin
      bus.xpos = 12'(vecs[i].x);
      bus.ypos = 12'(vecs[i].y);
      push_exp(vecs[i].valid, vecs[i].col, vecs[i].row);
      tick();
      pop_exp(e);
      chk($sformatf("hover_valid_%0d", i), bus.hover_valid, e.valid);
      chk($sformatf("hover_col_%0d", i),   bus.hover_col,   e.col);
      chk($sformatf("hover_row_%0d", i),   bus.hover_row,   e.row);
    end

    // Stalled consumer: exact three-edge latency then hold.
    bus.xpos = 12'd170;
    bus.ypos = 12'd90;
    tick();
    bus.left = 1'b1;
    push_exp(1, 2, 1);
    tick();
    tick();
    tick();
    chk("latency_before_n3", bus.click_valid, 0);
    tick();
    chk("latency_at_n3", bus.click_valid, 1);
    check_click("stall_click");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.click_valid) seen++;
    end
    chk("stall_hold_cycles", seen, 10);
    chk("stall_col_stable", bus.click_col, 2);
    bus.click_ready = 1'b1;
    tick();
    bus.click_ready = 1'b0;
    chk("stall_consumed", bus.click_valid, 0);
    bus.left = 1'b0;
    repeat (4) tick();
    chk("held_col_after_consume", bus.click_col, 2);

    // Press outside the grid, then drag inside while held.
    bus.xpos = 12'd50;
    bus.ypos = 12'd50;
    bus.left = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.click_valid) seen++;
    end
    chk("outside_no_click", seen, 0);
    bus.xpos = 12'd170;
    bus.ypos = 12'd90;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.click_valid) seen++;
    end
    chk("drag_in_no_click", seen, 0);
    bus.left = 1'b0;
    repeat (4) tick();
    bus.left = 1'b1;
    push_exp(1, 2, 1);
    wait_valid("repress", ok);
    check_click("repress_click");

    // Reset while pending, button still held.
    tick();
    rst_n = 1'b0;
    #2;
    chk("arst_click_valid", bus.click_valid, 0);
    chk("arst_click_col",   bus.click_col,   0);
    chk("arst_click_row",   bus.click_row,   0);
    chk("arst_hover_valid", bus.hover_valid, 0);
    chk("arst_hover_row",   bus.hover_row,   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(1, 2, 1);
    wait_valid("post_reset", ok);
    check_click("post_reset_click");
    bus.click_ready = 1'b1;
    tick();
    bus.click_ready = 1'b0;
    chk("post_reset_consumed", bus.click_valid, 0);
    bus.left = 1'b0;
    repeat (4) tick();

    // Sweep every cell centre with the consumer always ready.
    acc0 = accepted;
    bus.click_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 12; c++) begin
        bus.xpos = 12'(XO + 32 * c + 17);
        bus.ypos = 12'(YO + 32 * r + 17);
        push_exp(1, c, r);
        bus.left = 1'b1;
        wait_valid($sformatf("sweep_%0d_%0d", r, c), ok);
        if (ok) begin
          check_click($sformatf("sweep_%0d_%0d", r, c));
          chk($sformatf("sweep_hover_col_%0d_%0d", r, c), bus.hover_col, c);
          chk($sformatf("sweep_hover_row_%0d_%0d", r, c), bus.hover_row, r);
        end else begin
          pop_exp(e);
        end
        bus.left = 1'b0;
        repeat (4) tick();
      end
    end
    bus.click_ready = 1'b0;
    chk("sweep_accept_count", accepted - acc0, 144);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
